// File: rtl/cla_sub_pipe.sv
// Pipelined N-bit carry-lookahead subtractor D = A - B - Bin, one 4-bit lookahead slice per stage.
// Latency: a beat accepted at edge t is presented at the outputs after edge t + N/4 - 1.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready is low then and during rst.
module cla_sub_pipe #(
    parameter int N = 16    // multiple of 4, at least 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         V,
    output logic         Z
);

    localparam int STAGES = N / 4;

    // Subtraction runs as A + ~B + ~Bin, so nb is the inverted subtrahend
    // and c0 is the inverted borrow. Full 4-bit lookahead, no internal ripple.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] nb, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = a ^ nb;
        g  = a & nb;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Single global advance: either the output slot is empty or it is being drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // Stages 1..STAGES-1 are internal registers; stage STAGES is the output register set.
    // Stage k holds difference bits [4k-1:0], the carry into slice k and only the
    // operand bits not yet consumed (bit 0 of opa/opnb is original bit 4k).
    for (genvar k = 1; k < STAGES; k++) begin : g_st
        logic               vld;
        logic [4*k-1:0]     dif;
        logic               cy;
        logic [N-4*k-1:0]   opa;
        logic [N-4*k-1:0]   opnb;
        logic               amsb;
        logic               bmsb;

        // Source of this stage: the input beat for stage 1, otherwise the previous stage.
        logic               sv;
        logic [N-4*k+3:0]   sa;
        logic [N-4*k+3:0]   snb;
        logic               sc;
        logic               sam;
        logic               sbm;
        logic [4:0]         sl;
        logic [4*k-1:0]     dif_n;

        assign sl = cla4(sa[3:0], snb[3:0], sc);

        if (k == 1) begin : g_src
            assign sv    = in_valid;
            assign sa    = A;
            assign snb   = ~B;
            assign sc    = ~Bin;
            assign sam   = A[N-1];
            assign sbm   = B[N-1];
            assign dif_n = sl[3:0];
        end else begin : g_src
            assign sv    = g_st[k-1].vld;
            assign sa    = g_st[k-1].opa;
            assign snb   = g_st[k-1].opnb;
            assign sc    = g_st[k-1].cy;
            assign sam   = g_st[k-1].amsb;
            assign sbm   = g_st[k-1].bmsb;
            assign dif_n = {sl[3:0], g_st[k-1].dif};
        end

        // Shift this stage forward on advance; bubbles shift like beats.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld  <= 1'b0;
                dif  <= '0;
                cy   <= 1'b0;
                opa  <= '0;
                opnb <= '0;
                amsb <= 1'b0;
                bmsb <= 1'b0;
            end else if (adv) begin
                vld  <= sv;
                dif  <= dif_n;
                cy   <= sl[4];
                opa  <= sa[N-4*k+3:4];
                opnb <= snb[N-4*k+3:4];
                amsb <= sam;
                bmsb <= sbm;
            end
        end
    end

    // Top slice and full-width flags, evaluated as a beat enters the output stage.
    logic [4:0]   fsl;
    logic [N-1:0] fd;
    logic         fam;
    logic         fbm;
    assign fsl = cla4(g_st[STAGES-1].opa, g_st[STAGES-1].opnb, g_st[STAGES-1].cy);
    assign fd  = {fsl[3:0], g_st[STAGES-1].dif};
    assign fam = g_st[STAGES-1].amsb;
    assign fbm = g_st[STAGES-1].bmsb;

    // Output register: results only update on a valid beat so idle input data never shows.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
        end else if (adv) begin
            out_valid <= g_st[STAGES-1].vld;
            if (g_st[STAGES-1].vld) begin
                D    <= fd;
                Bout <= ~fsl[4];
                V    <= (fam != fbm) && (fd[N-1] != fam);
                Z    <= (fd == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed and streaming checks for the pipelined CLA subtractor (N = 16).
// Vectors run one at a time through an empty pipe, then a back-pressured stream,
// then a reset with beats in flight.
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_sub_pipe #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: 17-bit wide difference, bit 16 is the borrow.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] diff;
        logic [15:0] d;
        logic        v;
        diff = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        d    = diff[15:0];
        v    = (a[15] != b[15]) && (d[15] != a[15]);
        return {d, diff[16], v, (d == 16'h0000)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] expq [$];
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic        sbin [8];
        logic [18:0] held;
        int          lat;
        int          idx;
        int          got;
        int          stall_cnt;
        int          seen;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        // Reset held for two edges with a valid beat offered.
        rst       = 1'b1;
        in_valid  = 1'b1;
        A         = 16'h1234;
        B         = 16'h0001;
        Bin       = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_D", 32'(D), 32'h0000);
        chk("reset_flags", 32'({Bout, V, Z}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (out_valid) seen++;
        end
        chk("reset_accept_ignored", 32'(seen), 32'd0);

        // Directed vectors, one beat at a time through an empty pipe.
        for (int i = 0; i < 8; i++) begin
            A        = vecs[i].a;
            B        = vecs[i].b;
            Bin      = vecs[i].bin;
            in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick;
            in_valid = 1'b0;
            A        = 16'hA5A5;
            B        = 16'h5A5A;
            Bin      = 1'b1;
            lat      = 0;
            while (!out_valid && lat < 10) begin
                tick;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_D", i), 32'(D), 32'(vecs[i].d));
            chk($sformatf("vec%0d_flags", i), 32'({Bout, V, Z}),
                32'({vecs[i].bout, vecs[i].v, vecs[i].z}));
            tick;
            chk($sformatf("vec%0d_consumed", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back stream with out_ready low for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            sa[i]   = 16'($urandom);
            sb[i]   = 16'($urandom);
            sbin[i] = 1'($urandom_range(0, 1));
        end
        idx       = 0;
        got       = 0;
        stall_cnt = 0;
        held      = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (idx < 8) begin
                in_valid = 1'b1;
                A        = sa[idx];
                B        = sb[idx];
                Bin      = sbin[idx];
            end else begin
                in_valid = 1'b0;
                A        = 16'hDEAD;
                B        = 16'hBEEF;
                Bin      = 1'b1;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (stall_cnt > 0) chk("stall_result_stable", 32'({D, Bout, V, Z}), 32'(held));
                held = {D, Bout, V, Z};
                stall_cnt++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("stream_extra", 32'(out_valid), 32'd0);
                else chk($sformatf("stream_result%0d", got), 32'({D, Bout, V, Z}), 32'(expq.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(A, B, Bin));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(got), 32'd8);
        chk("stall_cycles", 32'(stall_cnt), 32'd3);

        // Reset with three beats in flight; none of them may ever appear.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A        = 16'(16'h0100 * (i + 1));
            B        = 16'h0001;
            Bin      = 1'b0;
            tick;
        end
        rst = 1'b1;
        tick;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_D", 32'(D), 32'h0000);
        rst      = 1'b0;
        in_valid = 1'b0;
        seen     = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (out_valid) seen++;
        end
        chk("midreset_no_emit", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
